hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline interlock controller for the 5-stage MIPS core. It sits beside the forwarding unit, between the IF/ID, ID/EX and EX/MEM pipeline registers.
- Generates PC/IF-ID write enables, ID/EX bubble, IF/ID flush and EX hold for three cases: load-use hazards, multi-cycle MUL occupancy of EX, and taken-branch flushes.
- Load-use and branch handling are single-cycle combinational decisions. MUL occupancy is sequenced by a registered FSM plus down-counter.

Parameters:
- LOAD_OPCODE, 6'b100011, ID/EX opcode treated as a load.
- MUL_OPCODE, 6'b011100, ID/EX opcode treated as a multi-cycle multiply.
- MUL_LAT, 4, total EX-stage cycles for MUL; legal 1..16; 1 disables MUL stalling.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- IF_ID_opcode  input  6  opcode of instruction in ID.
- IF_ID_rs  input  5  rs of instruction in ID.
- IF_ID_rt  input  5  rt of instruction in ID.
- IF_ID_uses_rt  input  1  1 = ID instruction reads rt as a source.
- ID_EX_opcode  input  6  opcode of instruction in EX.
- ID_EX_rd  input  5  destination register of instruction in EX.
- branch_taken  input  1  EX-resolved taken branch/jump this cycle.
- pc_write  output  1  1 = PC may update.
- IF_ID_write  output  1  1 = IF/ID register may load.
- ID_EX_bubble  output  1  1 = load NOP into ID/EX.
- IF_ID_flush  output  1  1 = clear IF/ID to NOP.
- ex_hold  output  1  1 = hold ID/EX contents and load NOP into EX/MEM.
- mul_done  output  1  one-cycle pulse on the cycle MUL leaves EX.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-low reset rst_n, sampled on the rising edge.
- Reset (rst_n=0 at edge): state<=RUN, cnt<=0.
- While rst_n=0, outputs are forced to idle values: pc_write=1, IF_ID_write=1, ID_EX_bubble=0, IF_ID_flush=0, ex_hold=0, mul_done=0.
- Reset asserted mid-BUSY aborts the MUL stall. The next cycle is RUN with idle outputs.
- State register: RUN, BUSY. Counter cnt is 4 bits.
- Hazard detection terms:
  - load_use = (ID_EX_opcode==LOAD_OPCODE) && (ID_EX_rd!=0) && ((ID_EX_rd==IF_ID_rs) || (IF_ID_uses_rt && ID_EX_rd==IF_ID_rt)).
  - mul_start = (ID_EX_opcode==MUL_OPCODE) && (MUL_LAT>1).
- RUN decisions, in priority order:
  1. branch_taken: IF_ID_flush=1, ID_EX_bubble=1, pc_write=1, IF_ID_write=1. Overrides load_use. State stays RUN.
  2. mul_start: pc_write=0, IF_ID_write=0, ex_hold=1. Next state BUSY, cnt<=MUL_LAT-2.
  3. load_use: pc_write=0, IF_ID_write=0, ID_EX_bubble=1 for exactly this cycle. Next cycle the load is in MEM and forwarding resolves the dependence.
  4. Otherwise: idle values.
- BUSY:
  - cnt!=0: pc_write=0, IF_ID_write=0, ex_hold=1, cnt<=cnt-1.
  - cnt==0: idle values, mul_done=1, next state RUN. MUL advances to EX/MEM on this edge.
- Total stall cycles for one MUL = MUL_LAT-1. Back-to-back MULs each incur the full stall, with no re-trigger on the release cycle.
- branch_taken and load_use are ignored in BUSY. Contract: EX holds a MUL, never a branch or load, during BUSY.
- ID_EX_rd==0 never produces a load-use stall.
- Outputs are combinational from state, cnt and inputs. No output depends on a previous-cycle input except via state/cnt.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds three outputs, each 16 bits, saturating at 16'hFFFF, cleared by reset:
  - load_stall_cnt: +1 per load_use stall cycle.
  - mul_stall_cnt: +1 per MUL stall cycle.
  - flush_cnt: +1 per branch_taken flush cycle.
- Undefined: ports and logic are absent; core behaviour is identical.

Test Plan:
- Load-use: ID_EX_opcode=100011, ID_EX_rd=5, IF_ID_rs=5 -> one cycle of pc_write=0, IF_ID_write=0, ID_EX_bubble=1; with the ID instruction's rs then changed to 0, next cycle idle.
- Load-use on rt: ID_EX_rd=7, IF_ID_rt=7 -> stall when IF_ID_uses_rt=1, no stall when IF_ID_uses_rt=0. ID_EX_rd=0, IF_ID_rs=0 -> no stall.
- MUL, MUL_LAT=4: MUL held in ID/EX -> ex_hold=1 for 3 consecutive cycles, then one cycle with mul_done=1 and idle enables. Repeat with MUL_LAT=1 -> no stall, no mul_done.
- Priority: branch_taken=1 together with a load_use match -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1, IF_ID_write=1.
- Reset mid-BUSY: rst_n=0 on the second stall cycle -> outputs idle immediately; after release, no mul_done pulse and state RUN.
- With HAZARD_PERF_CNT_EN: 2 load stalls, 1 MUL (MUL_LAT=4), 1 flush -> load_stall_cnt=2, mul_stall_cnt=3, flush_cnt=1. Forced near 16'hFFFF -> counters saturate, no wrap.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock for the 5-stage core: load-use bubbles, multi-cycle MUL hold, taken-branch flush.
// Optional saturating performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter logic [5:0] LOAD_OPCODE = 6'b100011,
  parameter logic [5:0] MUL_OPCODE  = 6'b011100,
  parameter int         MUL_LAT     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  IF_ID_opcode,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        IF_ID_uses_rt,
  input  logic [5:0]  ID_EX_opcode,
  input  logic [4:0]  ID_EX_rd,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        IF_ID_write,
  output logic        ID_EX_bubble,
  output logic        IF_ID_flush,
  output logic        ex_hold,
`ifdef HAZARD_PERF_CNT_EN
  output logic [15:0] load_stall_cnt,
  output logic [15:0] mul_stall_cnt,
  output logic [15:0] flush_cnt,
`endif
  output logic        mul_done
);

  typedef enum logic {RUN, BUSY} state_t;

  localparam bit         MUL_EN       = (MUL_LAT > 1);
  localparam logic [3:0] MUL_CNT_INIT = MUL_EN ? 4'(MUL_LAT - 2) : 4'd0;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       load_use, mul_start;
  logic       load_stall_evt, mul_stall_evt, flush_evt;

  // The ID opcode plays no part in the interlock decision.
  logic unused_if_id_opcode;
  assign unused_if_id_opcode = ^IF_ID_opcode;

  assign load_use = (ID_EX_opcode == LOAD_OPCODE) && (ID_EX_rd != 5'd0) &&
                    ((ID_EX_rd == IF_ID_rs) || (IF_ID_uses_rt && (ID_EX_rd == IF_ID_rt)));
  assign mul_start = (ID_EX_opcode == MUL_OPCODE) && MUL_EN;

  always_comb begin
    pc_write       = 1'b1;
    IF_ID_write    = 1'b1;
    ID_EX_bubble   = 1'b0;
    IF_ID_flush    = 1'b0;
    ex_hold        = 1'b0;
    mul_done       = 1'b0;
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    load_stall_evt = 1'b0;
    mul_stall_evt  = 1'b0;
    flush_evt      = 1'b0;
    if (!rst_n) begin
      state_next = RUN;
      cnt_next   = 4'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (branch_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
            flush_evt    = 1'b1;
          end else if (mul_start) begin
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ex_hold       = 1'b1;
            mul_stall_evt = 1'b1;
            state_next    = BUSY;
            cnt_next      = MUL_CNT_INIT;
          end else if (load_use) begin
            pc_write       = 1'b0;
            IF_ID_write    = 1'b0;
            ID_EX_bubble   = 1'b1;
            load_stall_evt = 1'b1;
          end
        end
        BUSY: begin
          // Release cycle leaves the enables idle so the MUL drains into EX/MEM.
          if (cnt_reg != 4'd0) begin
            pc_write      = 1'b0;
            IF_ID_write   = 1'b0;
            ex_hold       = 1'b1;
            mul_stall_evt = 1'b1;
            cnt_next      = cnt_reg - 4'd1;
          end else begin
            mul_done   = 1'b1;
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= RUN;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [2:0]  perf_evt;
  logic [15:0] perf_cnt_reg [3];

  assign perf_evt = {flush_evt, mul_stall_evt, load_stall_evt};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
      always_ff @(posedge clk) begin
        if (!rst_n)
          perf_cnt_reg[gi] <= 16'd0;
        else if (perf_evt[gi] && (perf_cnt_reg[gi] != 16'hFFFF))
          perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 16'd1;
      end
    end
  endgenerate

  assign load_stall_cnt = perf_cnt_reg[0];
  assign mul_stall_cnt  = perf_cnt_reg[1];
  assign flush_cnt      = perf_cnt_reg[2];
`else
  logic unused_perf_evt;
  assign unused_perf_evt = load_stall_evt ^ mul_stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: expected output vectors are queued as each step is driven.
// Output vector order: {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ex_hold, mul_done}.
module tb_hazard_stall_ctrl;

  localparam logic [5:0] LD  = 6'b100011;
  localparam logic [5:0] MUL = 6'b011100;
  localparam logic [5:0] NOP = 6'b000000;

  localparam logic [5:0] IDLE  = 6'b110000;
  localparam logic [5:0] LSTL  = 6'b001000;
  localparam logic [5:0] BRCH  = 6'b111100;
  localparam logic [5:0] HOLD  = 6'b000010;
  localparam logic [5:0] DONE  = 6'b110001;

  typedef struct {
    logic       rst_n;
    logic [5:0] ex_op;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       br;
    logic [5:0] exp;
    logic [5:0] exp1;
  } step_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] IF_ID_opcode;
  logic [4:0] IF_ID_rs, IF_ID_rt;
  logic IF_ID_uses_rt;
  logic [5:0] ID_EX_opcode;
  logic [4:0] ID_EX_rd;
  logic branch_taken;
  logic pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ex_hold, mul_done;
  logic pc_write1, IF_ID_write1, ID_EX_bubble1, IF_ID_flush1, ex_hold1, mul_done1;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] load_stall_cnt, mul_stall_cnt, flush_cnt;
  logic [15:0] load_stall_cnt1, mul_stall_cnt1, flush_cnt1;
`endif

  int checks = 0;
  int failures = 0;
  logic [5:0] sb_q[$];
  logic [5:0] sb1_q[$];

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MUL_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .IF_ID_opcode(IF_ID_opcode), .IF_ID_rs(IF_ID_rs),
    .IF_ID_rt(IF_ID_rt), .IF_ID_uses_rt(IF_ID_uses_rt), .ID_EX_opcode(ID_EX_opcode),
    .ID_EX_rd(ID_EX_rd), .branch_taken(branch_taken), .pc_write(pc_write),
    .IF_ID_write(IF_ID_write), .ID_EX_bubble(ID_EX_bubble), .IF_ID_flush(IF_ID_flush),
    .ex_hold(ex_hold),
`ifdef HAZARD_PERF_CNT_EN
    .load_stall_cnt(load_stall_cnt), .mul_stall_cnt(mul_stall_cnt), .flush_cnt(flush_cnt),
`endif
    .mul_done(mul_done)
  );

  hazard_stall_ctrl #(.MUL_LAT(1)) dut_lat1 (
    .clk(clk), .rst_n(rst_n), .IF_ID_opcode(IF_ID_opcode), .IF_ID_rs(IF_ID_rs),
    .IF_ID_rt(IF_ID_rt), .IF_ID_uses_rt(IF_ID_uses_rt), .ID_EX_opcode(ID_EX_opcode),
    .ID_EX_rd(ID_EX_rd), .branch_taken(branch_taken), .pc_write(pc_write1),
    .IF_ID_write(IF_ID_write1), .ID_EX_bubble(ID_EX_bubble1), .IF_ID_flush(IF_ID_flush1),
    .ex_hold(ex_hold1),
`ifdef HAZARD_PERF_CNT_EN
    .load_stall_cnt(load_stall_cnt1), .mul_stall_cnt(mul_stall_cnt1), .flush_cnt(flush_cnt1),
`endif
    .mul_done(mul_done1)
  );

  // Applies one step's inputs half a cycle before the next rising edge and queues its expectations.
  task automatic drive_step(input step_t s);
    @(negedge clk);
    rst_n         = s.rst_n;
    IF_ID_opcode  = NOP;
    ID_EX_opcode  = s.ex_op;
    ID_EX_rd      = s.rd;
    IF_ID_rs      = s.rs;
    IF_ID_rt      = s.rt;
    IF_ID_uses_rt = s.uses_rt;
    branch_taken  = s.br;
    sb_q.push_back(s.exp);
    sb1_q.push_back(s.exp1);
  endtask

  task automatic test_reset();
    step_t steps[3];
    logic [5:0] e, e1;
    steps[0] = '{1'b0, LD,  5'd5, 5'd5, 5'd0, 1'b0, 1'b0, IDLE, IDLE};
    steps[1] = '{1'b0, MUL, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, IDLE, IDLE};
    steps[2] = '{1'b1, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, IDLE, IDLE};
    foreach (steps[i]) begin
      drive_step(steps[i]);
      #1;
      e = sb_q.pop_front();
      e1 = sb1_q.pop_front();
      checks++;
      if ({pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ex_hold, mul_done} !== e ||
          {pc_write1, IF_ID_write1, ID_EX_bubble1, IF_ID_flush1, ex_hold1, mul_done1} !== e1) begin
        failures++;
        $display("FAIL reset step %0d: got %b/%b expected %b/%b", i,
          {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ex_hold, mul_done},
          {pc_write1, IF_ID_write1, ID_EX_bubble1, IF_ID_flush1, ex_hold1, mul_done1}, e, e1);
      end else $display("reset step %0d ok: %b", i, e);
    end
  endtask

  task automatic test_load_use();
    step_t steps[7];
    logic [5:0] e, e1;
    steps[0] = '{1'b1, LD,  5'd5, 5'd5, 5'd0, 1'b0, 1'b0, LSTL, LSTL};
    steps[1] = '{1'b1, LD,  5'd5, 5'd0, 5'd0, 1'b0, 1'b0, IDLE, IDLE};
    steps[2] = '{1'b1, LD,  5'd7, 5'd3, 5'd7, 1'b1, 1'b0, LSTL, LSTL};
    steps[3] = '{1'b1, LD,  5'd7, 5'd3, 5'd7, 1'b0, 1'b0, IDLE, IDLE};
    steps[4] = '{1'b1, LD,  5'd0, 5'd0, 5'd0, 1'b1, 1'b0, IDLE, IDLE};
    steps[5] = '{1'b1, NOP, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, IDLE, IDLE};
    steps[6] = '{1'b1, LD,  5'd31, 5'd31, 5'd2, 1'b1, 1'b0, LSTL, LSTL};
    foreach (steps[i]) begin
      drive_step(steps[i]);
      #1;
      e = sb_q.pop_front();
      e1 = sb1_q.pop_front();
      checks++;
      if ({pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ex_hold, mul_done} !== e ||
          {pc_write1, IF_ID_write1, ID_EX_bubble1, IF_ID_flush1, ex_hold1, mul_done1} !== e1) begin
        failures++;
        $display("FAIL load_use step %0d: got %b/%b expected %b/%b", i,
          {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ex_hold, mul_done},
          {pc_write1, IF_ID_write1, ID_EX_bubble1, IF_ID_flush1, ex_hold1, mul_done1}, e, e1);
      end else $display("load_use step %0d ok: %b", i, e);
    end
  endtask

  task automatic test_priority();
    step_t steps[4];
    logic [5:0] e, e1;
    steps[0] = '{1'b1, LD,  5'd5, 5'd5, 5'd0, 1'b0, 1'b1, BRCH, BRCH};
    steps[1] = '{1'b1, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, BRCH, BRCH};
    steps[2] = '{1'b1, MUL, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1, BRCH, BRCH};
    steps[3] = '{1'b1, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, IDLE, IDLE};
    foreach (steps[i]) begin
      drive_step(steps[i]);
      #1;
      e = sb_q.pop_front();
      e1 = sb1_q.pop_front();
      checks++;
      if ({pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ex_hold, mul_done} !== e ||
          {pc_write1, IF_ID_write1, ID_EX_bubble1, IF_ID_flush1, ex_hold1, mul_done1} !== e1) begin
        failures++;
        $display("FAIL priority step %0d: got %b/%b expected %b/%b", i,
          {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ex_hold, mul_done},
          {pc_write1, IF_ID_write1, ID_EX_bubble1, IF_ID_flush1, ex_hold1, mul_done1}, e, e1);
      end else $display("priority step %0d ok: %b", i, e);
    end
  endtask

  // MUL held in EX: three hold cycles then a release pulse; the MUL_LAT=1 instance never stalls.
  // Load/branch inputs during BUSY must be ignored.
  task automatic test_back_to_back();
    step_t steps[10];
    logic [5:0] e, e1;
    steps[0] = '{1'b1, MUL, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, HOLD, IDLE};
    steps[1] = '{1'b1, MUL, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, HOLD, IDLE};
    steps[2] = '{1'b1, MUL, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, HOLD, IDLE};
    steps[3] = '{1'b1, MUL, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, DONE, IDLE};
    steps[4] = '{1'b1, MUL, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, HOLD, IDLE};
    steps[5] = '{1'b1, LD,  5'd6, 5'd6, 5'd0, 1'b0, 1'b0, HOLD, LSTL};
    steps[6] = '{1'b1, NOP, 5'd6, 5'd0, 5'd0, 1'b0, 1'b1, HOLD, BRCH};
    steps[7] = '{1'b1, MUL, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, DONE, IDLE};
    steps[8] = '{1'b1, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, IDLE, IDLE};
    steps[9] = '{1'b1, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, IDLE, IDLE};
    foreach (steps[i]) begin
      drive_step(steps[i]);
      #1;
      e = sb_q.pop_front();
      e1 = sb1_q.pop_front();
      checks++;
      if ({pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ex_hold, mul_done} !== e ||
          {pc_write1, IF_ID_write1, ID_EX_bubble1, IF_ID_flush1, ex_hold1, mul_done1} !== e1) begin
        failures++;
        $display("FAIL mul step %0d: got %b/%b expected %b/%b", i,
          {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ex_hold, mul_done},
          {pc_write1, IF_ID_write1, ID_EX_bubble1, IF_ID_flush1, ex_hold1, mul_done1}, e, e1);
      end else $display("mul step %0d ok: %b", i, e);
    end
  endtask

  task automatic test_reset_mid_busy();
    step_t steps[5];
    logic [5:0] e, e1;
    steps[0] = '{1'b1, MUL, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, HOLD, IDLE};
    steps[1] = '{1'b0, MUL, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, IDLE, IDLE};
    steps[2] = '{1'b1, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, IDLE, IDLE};
    steps[3] = '{1'b1, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, IDLE, IDLE};
    steps[4] = '{1'b1, LD,  5'd9, 5'd9, 5'd0, 1'b0, 1'b0, LSTL, LSTL};
    foreach (steps[i]) begin
      drive_step(steps[i]);
      #1;
      e = sb_q.pop_front();
      e1 = sb1_q.pop_front();
      checks++;
      if ({pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ex_hold, mul_done} !== e ||
          {pc_write1, IF_ID_write1, ID_EX_bubble1, IF_ID_flush1, ex_hold1, mul_done1} !== e1) begin
        failures++;
        $display("FAIL reset_mid_busy step %0d: got %b/%b expected %b/%b", i,
          {pc_write, IF_ID_write, ID_EX_bubble, IF_ID_flush, ex_hold, mul_done},
          {pc_write1, IF_ID_write1, ID_EX_bubble1, IF_ID_flush1, ex_hold1, mul_done1}, e, e1);
      end else $display("reset_mid_busy step %0d ok: %b", i, e);
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    step_t steps[9];
    steps[0] = '{1'b0, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, IDLE, IDLE};
    steps[1] = '{1'b1, LD,  5'd5, 5'd5, 5'd0, 1'b0, 1'b0, LSTL, LSTL};
    steps[2] = '{1'b1, LD,  5'd3, 5'd0, 5'd3, 1'b1, 1'b0, LSTL, LSTL};
    steps[3] = '{1'b1, MUL, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, HOLD, IDLE};
    steps[4] = '{1'b1, MUL, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, HOLD, IDLE};
    steps[5] = '{1'b1, MUL, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, HOLD, IDLE};
    steps[6] = '{1'b1, MUL, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, DONE, IDLE};
    steps[7] = '{1'b1, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, BRCH, BRCH};
    steps[8] = '{1'b1, NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, IDLE, IDLE};
    foreach (steps[i]) begin
      drive_step(steps[i]);
      void'(sb_q.pop_front());
      void'(sb1_q.pop_front());
    end
    #1;
    checks++;
    if ({load_stall_cnt, mul_stall_cnt, flush_cnt} !== {16'd2, 16'd3, 16'd1}) begin
      failures++;
      $display("FAIL perf_cnt: got load=%0d mul=%0d flush=%0d expected 2/3/1",
               load_stall_cnt, mul_stall_cnt, flush_cnt);
    end else $display("perf_cnt ok: load=2 mul=3 flush=1");
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    IF_ID_opcode = NOP; IF_ID_rs = '0; IF_ID_rt = '0; IF_ID_uses_rt = 1'b0;
    ID_EX_opcode = NOP; ID_EX_rd = '0; branch_taken = 1'b0;
    test_reset();
    test_load_use();
    test_priority();
    test_back_to_back();
    test_reset_mid_busy();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
